// File: rtl/flow_table_ctrl_pkg.sv
// rtl/flow_table_ctrl_pkg.sv - shared flow table types, miss constant and index hash
package flow_table_ctrl_pkg;

  localparam int TUPLE_W = 104;
  localparam int QID_W   = 8;
  localparam int HASH_W  = 16;

  typedef logic [TUPLE_W-1:0] tuple_t;
  typedef logic [QID_W-1:0]   queue_id_t;

  localparam queue_id_t QID_MISS = '1;

  typedef struct packed {
    logic      valid;
    tuple_t    tuple;
    queue_id_t queue_id;
  } fd_entry_t;

  typedef struct packed {
    tuple_t      tuple;
    queue_id_t   queue_id;
    logic [15:0] pkt_len;
    logic [7:0]  in_port;
  } metadata_t;

  typedef enum logic { ST_INIT, ST_RUN } ctrl_state_t;

  // Bit i of the tuple lands in bit (i mod idx_w): XOR of idx_w-wide slices, top slice zero-padded.
  function automatic logic [HASH_W-1:0] fd_hash(input tuple_t t, input int idx_w);
    logic [HASH_W-1:0] h;
    h = '0;
    for (int i = 0; i < TUPLE_W; i++) h[4'(i % idx_w)] ^= t[i];
    return h;
  endfunction

endpackage

// File: rtl/fd_table_ram.sv
// rtl/fd_table_ram.sv - single-port read-first table RAM with registered read
module fd_table_ram
  import flow_table_ctrl_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  fd_entry_t                wdata,
  output fd_entry_t                rdata
);

  fd_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/flow_table_ctrl.sv
// rtl/flow_table_ctrl.sv - direct-mapped flow table lookup with host writes and post-reset clear
module flow_table_ctrl
  import flow_table_ctrl_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  metadata_t   in_meta_data,
  input  logic        in_meta_valid,
  output logic        in_meta_ready,
  output metadata_t   out_meta_data,
  output logic        out_meta_valid,
  input  logic        out_meta_ready,
  input  logic        cfg_wr_valid,
  output logic        cfg_wr_ready,
  input  tuple_t      cfg_wr_tuple,
  input  queue_id_t   cfg_wr_qid,
  input  logic        cfg_wr_del,
  output logic        init_done,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  ctrl_state_t      state;
  logic [IDX_W-1:0] init_idx;
  logic             last_grant;  // 1: write won the last contended cycle
  logic             s1_valid;
  metadata_t        s1_data;
  logic             rd_ok;       // RAM output holds a read of S1's index issued last cycle

  logic             s1_adv, lk_elig, wr_elig, grant_lk, grant_wr, hit;
  logic             ram_en, ram_we;
  logic [IDX_W-1:0] ram_addr;
  fd_entry_t        ram_wdata, ram_rdata;

  fd_table_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign s1_adv   = s1_valid && rd_ok && (!out_meta_valid || out_meta_ready);
  assign lk_elig  = (state == ST_RUN) && in_meta_valid && (!s1_valid || s1_adv);
  assign wr_elig  = (state == ST_RUN) && cfg_wr_valid;
  assign grant_wr = wr_elig && (!lk_elig || !last_grant);
  assign grant_lk = lk_elig && !grant_wr;
  assign in_meta_ready = grant_lk;
  assign cfg_wr_ready  = grant_wr;
  assign hit = ram_rdata.valid && (ram_rdata.tuple == s1_data.tuple);

  // A stalled S1 keeps re-reading its slot whenever the port is free, so host writes reach it.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = IDX_W'(fd_hash(s1_data.tuple, IDX_W));
    ram_wdata = '0;
    if (state == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = init_idx;
    end else if (grant_wr) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = IDX_W'(fd_hash(cfg_wr_tuple, IDX_W));
      ram_wdata = '{valid: !cfg_wr_del, tuple: cfg_wr_tuple, queue_id: cfg_wr_qid};
    end else if (grant_lk) begin
      ram_en   = 1'b1;
      ram_addr = IDX_W'(fd_hash(in_meta_data.tuple, IDX_W));
    end else if (s1_valid) begin
      ram_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_INIT;
      init_idx       <= '0;
      init_done      <= 1'b0;
      last_grant     <= 1'b0;
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      rd_ok          <= 1'b0;
      out_meta_valid <= 1'b0;
      out_meta_data  <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == IDX_W'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase

      if (lk_elig && wr_elig) last_grant <= grant_wr;
      rd_ok <= grant_lk || (s1_valid && !s1_adv && !grant_wr);

      if (grant_lk) begin
        s1_valid <= 1'b1;
        s1_data  <= in_meta_data;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_meta_valid         <= 1'b1;
        out_meta_data          <= s1_data;
        out_meta_data.queue_id <= hit ? ram_rdata.queue_id : QID_MISS;
        if (hit) hit_cnt  <= hit_cnt + 1'b1;
        else     miss_cnt <= miss_cnt + 1'b1;
      end else if (out_meta_ready) begin
        out_meta_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flow_table_ctrl.sv
// tb/tb_flow_table_ctrl.sv - directed scoreboard bench for flow_table_ctrl
module tb_flow_table_ctrl;
  import flow_table_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  metadata_t   in_meta_data = '0;
  logic        in_meta_valid = 1'b0;
  logic        in_meta_ready;
  metadata_t   out_meta_data;
  logic        out_meta_valid;
  logic        out_meta_ready = 1'b1;
  logic        cfg_wr_valid = 1'b0;
  logic        cfg_wr_ready;
  tuple_t      cfg_wr_tuple = '0;
  queue_id_t   cfg_wr_qid = '0;
  logic        cfg_wr_del = 1'b0;
  logic        init_done;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  flow_table_ctrl #(.DEPTH(1024)) dut (
    .clk(clk), .rst(rst),
    .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
    .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_tuple(cfg_wr_tuple),
    .cfg_wr_qid(cfg_wr_qid), .cfg_wr_del(cfg_wr_del),
    .init_done(init_done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int        vectors = 0;
  int        miscompares = 0;
  int        exp_hit = 0;
  int        exp_miss = 0;
  metadata_t sb[$];
  metadata_t mon_exp, prev_out;
  logic      prev_stall = 1'b0;

  always @(negedge clk) begin
    if (prev_stall) begin
      vectors++;
      assert (out_meta_valid === 1'b1 && out_meta_data === prev_out) else begin
        miscompares++;
        $error("FAIL hold_stable observed=%h/%b expected=%h/1", out_meta_data, out_meta_valid, prev_out);
      end
    end
    if (out_meta_valid === 1'b1 && out_meta_ready === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL unexpected_output observed=%h expected=none", out_meta_data);
      end else begin
        mon_exp = sb.pop_front();
        assert (out_meta_data === mon_exp) else begin
          miscompares++;
          $error("FAIL out_meta observed=%h expected=%h", out_meta_data, mon_exp);
        end
      end
    end
    prev_stall = out_meta_valid && !out_meta_ready;
    prev_out   = out_meta_data;
    if (rst) prev_stall = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic metadata_t mk(input tuple_t t);
    metadata_t m;
    m.tuple    = t;
    m.queue_id = 8'($urandom);
    m.pkt_len  = 16'($urandom);
    m.in_port  = 8'($urandom);
    return m;
  endfunction

  function automatic metadata_t expect_of(input metadata_t m, input queue_id_t q);
    metadata_t e;
    e = m;
    e.queue_id = q;
    return e;
  endfunction

  task automatic count_exp(input queue_id_t q);
    if (q == QID_MISS) exp_miss++;
    else exp_hit++;
  endtask

  task automatic do_lookup(input tuple_t t, input queue_id_t q);
    metadata_t m;
    int n;
    m = mk(t);
    @(posedge clk); #1;
    in_meta_data  = m;
    in_meta_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_meta_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) check("lookup_timeout", 0, 1);
    else begin
      sb.push_back(expect_of(m, q));
      count_exp(q);
    end
    @(posedge clk); #1;
    in_meta_valid = 1'b0;
  endtask

  task automatic do_write(input tuple_t t, input queue_id_t q, input logic del);
    int n;
    @(posedge clk); #1;
    cfg_wr_valid = 1'b1;
    cfg_wr_tuple = t;
    cfg_wr_qid   = q;
    cfg_wr_del   = del;
    n = 0;
    forever begin
      @(negedge clk);
      if (cfg_wr_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) check("write_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_wr_valid = 1'b0;
  endtask

  task automatic drain_and_count(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_meta_valid) && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    if (n >= 300) check({tag, "_drain_timeout"}, 0, 1);
    check({tag, "_hit_cnt"}, hit_cnt, exp_hit);
    check({tag, "_miss_cnt"}, miss_cnt, exp_miss);
  endtask

  task automatic reset_and_init();
    int n;
    @(posedge clk); #1;
    rst = 1'b1;
    in_meta_valid = 1'b0;
    cfg_wr_valid  = 1'b0;
    sb.delete();
    exp_hit  = 0;
    exp_miss = 0;
    @(posedge clk); #1;
    check("rst_out_valid", out_meta_valid, 0);
    check("rst_in_ready", in_meta_ready, 0);
    check("rst_cfg_ready", cfg_wr_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    out_meta_ready = 1'b1;
    in_meta_valid  = 1'b1;
    cfg_wr_valid   = 1'b1;
    n = 0;
    while (n < 1100) begin
      @(posedge clk); #1;
      n++;
      if (n == 500) begin
        check("init_in_ready", in_meta_ready, 0);
        check("init_cfg_ready", cfg_wr_ready, 0);
        in_meta_valid = 1'b0;
        cfg_wr_valid  = 1'b0;
      end
      if (init_done) break;
    end
    check("init_cycles", n, 1024);
  endtask

  localparam tuple_t TUP_A = 104'h5;
  localparam tuple_t TUP_B = 104'h404;  // slices 1 and 4 fold to index 5, same as A

  initial begin
    metadata_t lk[5];
    queue_id_t lq[5];
    metadata_t bm[3];
    int li, wi, bi;
    logic g_lk, g_wr, exp_w;

    reset_and_init();

    do_lookup(104'h7, QID_MISS);
    drain_and_count("idle_miss");

    do_write(TUP_A, 8'd5, 1'b0);
    do_lookup(TUP_A, 8'd5);
    @(negedge clk);
    check("lat_t1_valid", out_meta_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", out_meta_valid, 1);
    drain_and_count("hit_a");

    do_write(TUP_B, 8'd9, 1'b0);
    do_lookup(TUP_A, QID_MISS);
    do_lookup(TUP_B, 8'd9);
    do_write(TUP_B, 8'd0, 1'b1);
    do_lookup(TUP_B, QID_MISS);
    drain_and_count("collide");

    do_write(104'd201, 8'd31, 1'b0);
    do_write(104'd203, 8'd33, 1'b0);
    for (int i = 0; i < 5; i++) begin
      lk[i] = mk(104'(200 + i));
      lq[i] = (i == 1) ? 8'd31 : (i == 3) ? 8'd33 : QID_MISS;
    end
    @(posedge clk); #1;
    li = 0;
    wi = 0;
    in_meta_valid = 1'b1;
    in_meta_data  = lk[0];
    cfg_wr_valid  = 1'b1;
    cfg_wr_tuple  = 104'd100;
    cfg_wr_qid    = 8'd20;
    cfg_wr_del    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_w = (c % 2 == 0);
      g_lk = in_meta_ready;
      g_wr = cfg_wr_ready;
      check("arb_wr_grant", g_wr, exp_w);
      check("arb_lk_grant", g_lk, !exp_w);
      @(posedge clk); #1;
      if (g_lk && li < 5) begin
        sb.push_back(expect_of(lk[li], lq[li]));
        count_exp(lq[li]);
        li++;
        if (li < 5) in_meta_data = lk[li];
        else in_meta_valid = 1'b0;
      end
      if (g_wr && wi < 5) begin
        wi++;
        if (wi < 5) begin
          cfg_wr_tuple = 104'(100 + wi);
          cfg_wr_qid   = 8'(20 + wi);
        end else cfg_wr_valid = 1'b0;
      end
    end
    in_meta_valid = 1'b0;
    cfg_wr_valid  = 1'b0;
    check("arb_lookups", li, 5);
    check("arb_writes", wi, 5);
    do_lookup(104'd104, 8'd24);
    do_lookup(104'd100, 8'd20);
    drain_and_count("contend");

    for (int i = 0; i < 3; i++) bm[i] = mk(104'(300 + i));
    @(posedge clk); #1;
    out_meta_ready = 1'b0;
    in_meta_valid  = 1'b1;
    in_meta_data   = bm[0];
    bi = 0;
    for (int c = 0; c < 9 && bi < 3; c++) begin
      if (c == 6) out_meta_ready = 1'b1;
      @(negedge clk);
      g_lk = in_meta_ready;
      check("bp_in_ready", g_lk, (c < 2 || c >= 6));
      @(posedge clk); #1;
      if (g_lk) begin
        sb.push_back(expect_of(bm[bi], QID_MISS));
        count_exp(QID_MISS);
        bi++;
        if (bi < 3) in_meta_data = bm[bi];
        else in_meta_valid = 1'b0;
      end
    end
    in_meta_valid  = 1'b0;
    out_meta_ready = 1'b1;
    check("bp_accepted", bi, 3);
    drain_and_count("backpressure");

    do_write(104'd400, 8'd44, 1'b0);
    out_meta_ready = 1'b0;
    do_lookup(104'd400, 8'd44);
    reset_and_init();
    do_lookup(104'd400, QID_MISS);
    drain_and_count("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flow_table_ctrl.md
# flow_table_ctrl

Direct-mapped flow table controller in front of `flow_director`. It assigns each packet's `queue_id` by looking up `tuple`. It shares one single-port table RAM between the metadata lookup stream and host configuration writes using alternating-priority arbitration. It also runs a post-reset clear sequence. A lookup miss yields `queue_id = '1`, which the downstream flow director turns into `PKT_DROP`.

## Interface
- `DEPTH`, 1024: table entries; power of two, ≥ 2.
- `IDX_W`, $clog2(DEPTH): index width; derived, not overridden.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_meta_data`  in  metadata_t: metadata from parser; `tuple` is the lookup key.
- `in_meta_valid`  in  1: valid/ready handshake.
- `in_meta_ready`  out  1: handshake.
- `out_meta_data`  out  metadata_t: input metadata with `queue_id` replaced; other fields pass through unchanged.
- `out_meta_valid`  out  1: handshake.
- `out_meta_ready`  in  1: handshake.
- `cfg_wr_valid`  in  1: host rule write request.
- `cfg_wr_ready`  out  1: write accepted this cycle.
- `cfg_wr_tuple`  in  tuple_t: rule key.
- `cfg_wr_qid`  in  queue_id_t: rule queue.
- `cfg_wr_del`  in  1: 1 invalidates the entry at the hashed index; qid is ignored.
- `init_done`  out  1: high once the clear sequence completes.
- `hit_cnt`  out  32: lookups that matched; wraps.
- `miss_cnt`  out  32: lookups that missed; wraps.

## Operation
- Entry format: {valid, tuple, queue_id}.
- Index = XOR of consecutive IDX_W-bit slices of `tuple`, LSB-first; the top slice is zero-padded.
- Collisions: a later write overwrites the earlier entry.
- FSM `INIT`: entered on reset.
  - Writes valid=0 to index 0..DEPTH-1, one per cycle.
  - `in_meta_ready = 0`, `cfg_wr_ready = 0`.
  - After the last index, move to `RUN` and set `init_done = 1`.
- FSM `RUN`: one RAM operation per cycle.
  - Lookup is eligible when `in_meta_valid` is high and stage S1 can accept: S1 is empty, or S1 advances this cycle.
  - Write is eligible when `cfg_wr_valid` is high.
  - If only one is eligible, it is granted.
  - If both are eligible, grant the one opposite `last_grant`; `last_grant` updates on every contended grant.
  - `in_meta_ready` and `cfg_wr_ready` each equal their grant. Both are combinational from valid signals and state.
- Lookup pipeline:
  - Accept cycle: RAM read issued; metadata registered into S1.
  - Next cycle: RAM data compared with `tuple`. Hit = valid && tuple equal.
  - Result loads the output register when it is empty or `out_meta_ready` is high.
  - On hit, `queue_id` = entry qid and `hit_cnt` increments. On miss, `queue_id` = all ones and `miss_cnt` increments.
  - Counters increment when the result loads the output register.
- S1 stall: if the output register is full and `out_meta_ready` is low, S1 holds and re-issues its read address every cycle.
  - Writes granted during the stall are visible to the stalled lookup.
  - The result reflects the table as of the cycle before it loads the output register.
- RAM is read-first: a write and a read of the same index in the same cycle return old data. In practice only one is granted per cycle.
- Deleting a nonexistent or mismatched entry still clears the indexed slot.

## Timing
- Reset values: `out_meta_valid = 0`, `in_meta_ready = 0`, `cfg_wr_ready = 0`, `init_done = 0`, counters 0, `last_grant = 0` (write wins first contention), FSM `INIT`, S1 empty.
- `rst` asserted mid-operation: in-flight lookups are discarded and `INIT` restarts from index 0.
- INIT takes DEPTH cycles. `init_done` rises on cycle DEPTH after reset deassert; reset deassert is cycle 0.
- Lookup latency: accepted at cycle t, `out_meta_valid` at t+2 with no backpressure.
- Throughput: 1 lookup/cycle uncontended; ≥ 1 lookup per 2 cycles under continuous writes.
- A write accepted at t is visible to lookups accepted at t+1 or later.
- Output holds data stable while `out_meta_valid && !out_meta_ready`.

## Structure
- Shared package `my_struct_s.sv` gains `tuple_t`, `queue_id_t` and `fd_entry_t` {valid, tuple, queue_id}.
  - `metadata_t` uses these types.
- Miss queue-id constant `QID_MISS = '1` is defined in the package.
- Sub-module `fd_table_ram`: single-port, read-first, 1-cycle registered read, DEPTH × $bits(fd_entry_t).
- Hash is a package function `fd_hash(tuple_t)`.

## Test plan
- Reset, then idle: `init_done` rises at cycle 1024 (DEPTH=1024). Any lookup → `queue_id = '1`, `miss_cnt = 1`.
- Write tuple A → qid 5, then look up A: `out_meta_valid` 2 cycles after accept with `queue_id = 5`, `hit_cnt = 1`. Other fields are bit-identical to the input.
- Write B with the same hash as A → qid 9: A misses (`'1`), B hits 9. Delete B: B misses.
- Both valid continuously for 10 cycles: grants alternate starting with write. 5 writes and 5 lookups complete, and lookup order is preserved.
- `out_meta_ready` low for 6 cycles with 3 lookups pending: `in_meta_ready` drops once S1 is full. Output is held stable, and results drain in order with no loss or duplication.
- Assert `rst` for one cycle mid-stream after a rule was written: outputs return to reset values, INIT reruns, and the former rule now misses.
